// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready payload channel between two pipeline stages (control + data fields).
// The master drives valid/ctrl/data; the slave drives ready.
interface pipe_stage_skid_reg_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer and registered in_ready.
// Optional macro PIPE_BUBBLE_ZERO_EN forces out_ctrl/out_data to a bubble while out_valid=0.
module pipe_stage_skid_reg #(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 128,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
  input  logic                         cpu_clk_50M,
  input  logic                         cpu_rst_n,
  input  logic                         flush,
  pipe_stage_skid_reg_if.slave         src,
  pipe_stage_skid_reg_if.master        dst,
  output logic [1:0]                   occupancy
);

  logic              main_valid_reg, main_valid_next;
  logic              skid_valid_reg, skid_valid_next;
  logic [CTRL_W-1:0] main_ctrl_reg,  main_ctrl_next;
  logic [CTRL_W-1:0] skid_ctrl_reg,  skid_ctrl_next;
  logic [DATA_W-1:0] main_data_reg,  main_data_next;
  logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
  logic              in_ready_reg;
  logic [1:0]        occupancy_reg;

  logic accept;
  logic consume;

  assign accept  = src.valid & in_ready_reg;
  assign consume = main_valid_reg & dst.ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    main_ctrl_next  = main_ctrl_reg;
    skid_ctrl_next  = skid_ctrl_reg;
    main_data_next  = main_data_reg;
    skid_data_next  = skid_data_reg;

    if (flush) begin
      // Squash everything, including a transfer accepted in this very cycle.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
      main_ctrl_next  = CTRL_NOP;
      skid_ctrl_next  = CTRL_NOP;
      main_data_next  = '0;
      skid_data_next  = '0;
    end else if (!main_valid_reg) begin
      if (accept) begin
        main_valid_next = 1'b1;
        main_ctrl_next  = src.ctrl;
        main_data_next  = src.data;
      end
    end else if (consume) begin
      if (skid_valid_reg) begin
        main_ctrl_next  = skid_ctrl_reg;
        main_data_next  = skid_data_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_ctrl_next  = src.ctrl;
        main_data_next  = src.data;
      end else begin
        // Payload flops keep the consumed value; only the valid bit drops.
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_valid_next = 1'b1;
      skid_ctrl_next  = src.ctrl;
      skid_data_next  = src.data;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_ctrl_reg  <= CTRL_NOP;
      skid_ctrl_reg  <= CTRL_NOP;
      main_data_reg  <= '0;
      skid_data_reg  <= '0;
      in_ready_reg   <= 1'b1;
      occupancy_reg  <= 2'd0;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      main_ctrl_reg  <= main_ctrl_next;
      skid_ctrl_reg  <= skid_ctrl_next;
      main_data_reg  <= main_data_next;
      skid_data_reg  <= skid_data_next;
      // Derived from next-state so ready and occupancy stay flop outputs, free of out_ready.
      in_ready_reg   <= ~skid_valid_next;
      occupancy_reg  <= {1'b0, main_valid_next} + {1'b0, skid_valid_next};
    end
  end

  assign src.ready = in_ready_reg;
  assign dst.valid = main_valid_reg;
  assign occupancy = occupancy_reg;

`ifdef PIPE_BUBBLE_ZERO_EN
  assign dst.ctrl = main_valid_reg ? main_ctrl_reg : CTRL_NOP;
  assign dst.data = main_valid_reg ? main_data_reg : '0;
`else
  assign dst.ctrl = main_ctrl_reg;
  assign dst.data = main_data_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_pipe_stage_skid_reg;

  localparam int          CTRL_W   = 16;
  localparam int          DATA_W   = 128;
  localparam logic [15:0] CTRL_NOP = 16'h0000;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic       cpu_clk_50M = 1'b0;
  logic       cpu_rst_n   = 1'b0;
  logic       flush       = 1'b0;
  logic [1:0] occupancy;

  pipe_stage_skid_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) src ();
  pipe_stage_skid_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dst ();

  pipe_stage_skid_reg #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP (CTRL_NOP)
  ) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst_n   (cpu_rst_n),
    .flush       (flush),
    .src         (src),
    .dst         (dst),
    .occupancy   (occupancy)
  );

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  // Reference model: the register is a FIFO of depth 2; pend holds what upstream still offers.
  ent_t q[$];
  ent_t pend[$];
  ent_t last_head;
  int   errors = 0;
  int   checks = 0;
  bit   verbose = 1'b1;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.c = CTRL_W'($urandom);
    e.d = {$urandom, $urandom, $urandom, $urandom};
    return e;
  endfunction

  task automatic model_clear();
    q.delete();
    last_head.c = CTRL_NOP;
    last_head.d = '0;
  endtask

  task automatic check_outputs();
    ent_t e;
`ifdef PIPE_BUBBLE_ZERO_EN
    e.c = CTRL_NOP;
    e.d = '0;
`else
    e = last_head;
`endif
    if (q.size() > 0) e = q[0];
    check("out_valid", DATA_W'(dst.valid), DATA_W'(q.size() > 0));
    check("in_ready",  DATA_W'(src.ready), DATA_W'(q.size() < 2));
    check("occupancy", DATA_W'(occupancy), DATA_W'(q.size()));
    check("out_ctrl",  DATA_W'(dst.ctrl),  DATA_W'(e.c));
    check("out_data",  dst.data,           e.d);
  endtask

  task automatic model_update();
    bit room;
    ent_t e;
    if (!cpu_rst_n || flush) begin
      model_clear();
    end else begin
      room = (q.size() < 2);
      if (q.size() > 0 && dst.ready) begin
        e = q.pop_front();
        if (verbose) $display("xfer ctrl=%04h data=%0h", e.c, e.d);
      end
      if (src.valid && room) q.push_back(pend.pop_front());
      if (q.size() > 0) last_head = q[0];
    end
  endtask

  // Check just before the edge, advance the model on the edge, leave inputs free to change.
  task automatic step();
    @(negedge cpu_clk_50M);
    check_outputs();
    @(posedge cpu_clk_50M);
    model_update();
    #1;
  endtask

  task automatic drive(input bit en);
    ent_t junk;
    src.valid = en && (pend.size() > 0);
    if (pend.size() > 0) begin
      src.ctrl = pend[0].c;
      src.data = pend[0].d;
    end else begin
      junk     = rnd_ent();
      src.ctrl = junk.c;
      src.data = junk.d;
    end
  endtask

  task automatic push_ctrl(input logic [15:0] c);
    ent_t e;
    e   = rnd_ent();
    e.c = c;
    pend.push_back(e);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) begin
      drive(en);
      step();
    end
  endtask

  initial begin
    model_clear();
    src.valid = 1'b0;
    src.ctrl  = '0;
    src.data  = '0;
    dst.ready = 1'b0;

    // Reset state, then a 4-deep stream with the sink always ready.
    run(2, 1'b0);
    cpu_rst_n = 1'b1;
    dst.ready = 1'b1;
    for (int i = 0; i < 4; i++) push_ctrl(16'h0011 + 16'(i));
    run(7, 1'b1);

    // Back-pressure: A1 in main, A2 in skid, A3 waits upstream, then drain in order.
    dst.ready = 1'b0;
    push_ctrl(16'h00A1); push_ctrl(16'h00A2); push_ctrl(16'h00A3);
    run(4, 1'b1);
    check("bp_occ", DATA_W'(occupancy), DATA_W'(2));
    check("bp_rdy", DATA_W'(src.ready), DATA_W'(0));
    check("bp_head", DATA_W'(dst.ctrl), DATA_W'(16'h00A1));
    dst.ready = 1'b1;
    run(5, 1'b1);

    // Flush at occupancy 2 while BEEF is offered in the same cycle.
    dst.ready = 1'b0;
    push_ctrl(16'h0C01); push_ctrl(16'h0C02);
    run(3, 1'b1);
    pend.delete();
    push_ctrl(16'hBEEF);
    flush = 1'b1;
    run(1, 1'b1);
    flush = 1'b0;
    pend.delete();
    dst.ready = 1'b1;
    drive(1'b0);
    #2;
    check("fl_occ",   DATA_W'(occupancy), DATA_W'(0));
    check("fl_valid", DATA_W'(dst.valid), DATA_W'(0));
    check("fl_ctrl",  DATA_W'(dst.ctrl),  DATA_W'(CTRL_NOP));
    check("fl_rdy",   DATA_W'(src.ready), DATA_W'(1));
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_beef", DATA_W'(dst.valid && dst.ctrl == 16'hBEEF), DATA_W'(0));
    end

    // Asynchronous reset mid-cycle while full; outputs must clear before the next edge.
    dst.ready = 1'b0;
    push_ctrl(16'h0D01); push_ctrl(16'h0D02);
    run(3, 1'b1);
    #5;
    cpu_rst_n = 1'b0;
    #2;
    check("ar_valid", DATA_W'(dst.valid), DATA_W'(0));
    check("ar_rdy",   DATA_W'(src.ready), DATA_W'(1));
    check("ar_occ",   DATA_W'(occupancy), DATA_W'(0));
    check("ar_ctrl",  DATA_W'(dst.ctrl),  DATA_W'(CTRL_NOP));
    check("ar_data",  dst.data,           '0);
    model_clear();
    pend.delete();
    run(1, 1'b0);
    cpu_rst_n = 1'b1;
    dst.ready = 1'b1;
    for (int i = 0; i < 4; i++) push_ctrl(16'h0011 + 16'(i));
    run(7, 1'b1);

    // Bubble appearance after consuming 5A5A with nothing behind it.
    push_ctrl(16'h5A5A);
    run(4, 1'b1);
    check("bub_valid", DATA_W'(dst.valid), DATA_W'(0));
`ifdef PIPE_BUBBLE_ZERO_EN
    check("bub_ctrl", DATA_W'(dst.ctrl), DATA_W'(CTRL_NOP));
    check("bub_data", dst.data, '0);
`else
    check("bub_ctrl", DATA_W'(dst.ctrl), DATA_W'(16'h5A5A));
`endif

    // Randomized traffic against the model.
    verbose = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      while (pend.size() < 3) pend.push_back(rnd_ent());
      dst.ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0);
      step();
      check("rdy_vs_occ", DATA_W'(src.ready), DATA_W'(occupancy != 2'd2));
    end
    flush = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
